// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: read owner tag and the
// per-read tag record kept in issue order.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e                  owner;
        logic [ARB_ADDR_W-1:0]   addr;
    } arb_tag_t;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of the core fetch port, core data port, memory port and status.
// The arbiter is the slave; the environment (core + memory) is the master.
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [ADDR_W-1:0] if_raddr_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ready_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              err_o;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_raddr_o, if_rdata_o,
               d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_raddr_o, if_rdata_o,
               d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

endinterface

// File: rtl/imem_dmem_arbiter_tag_fifo.sv
// Synchronous FIFO of read tags in issue order; DEPTH must be a power of two
// so the pointers wrap naturally.
module arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  arb_tag_t push_data_i,
    input  logic     pop_i,
    output arb_tag_t pop_data_o,
    output logic     full_o,
    output logic     empty_o
);

    arb_tag_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o     = (r_count == CNT_W'(DEPTH));
    assign empty_o    = (r_count == {CNT_W{1'b0}});
    assign w_push     = push_i && !full_o;
    assign w_pop      = pop_i && !empty_o;
    assign pop_data_o = r_mem[r_rd_ptr];

    // Tag storage needs no reset: count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported memory between fetch and data ports: data-first
// arbitration with a starvation override, in-order response routing by tag.
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = ARB_ADDR_W,
    parameter int DATA_W          = ARB_DATA_W,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input logic                clk_i,
    input logic                rst_i,
    imem_dmem_arbiter_if.slave bus
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic              w_full;
    logic              w_empty;
    logic              w_if_elig;
    logic              w_d_elig;
    logic              w_if_gnt;
    logic              w_d_gnt;
    logic              w_push;
    logic              w_pop;
    arb_tag_t          w_push_tag;
    arb_tag_t          w_pop_tag;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    logic [SC_W-1:0]   r_starve_cnt;
    logic              r_if_rvalid;
    logic [ADDR_W-1:0] r_if_raddr;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_err;

    arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_tag),
        .pop_i       (w_pop),
        .pop_data_o  (w_pop_tag),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // Full comes from the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        w_if_gnt  = 1'b0;
        w_d_gnt   = 1'b0;
        w_if_elig = bus.if_req_i && !w_full;
        w_d_elig  = bus.d_req_i && (bus.d_we_i || !w_full);
        if (bus.mem_ready_i) begin
            if (w_if_elig && w_d_elig) begin
                if (r_starve_cnt == SC_W'(STARVE_LIMIT)) begin
                    w_if_gnt = 1'b1;
                end else begin
                    w_d_gnt = 1'b1;
                end
            end else begin
                w_if_gnt = w_if_elig;
                w_d_gnt  = w_d_elig;
            end
        end else begin
            w_if_gnt = 1'b0;
            w_d_gnt  = 1'b0;
        end
    end

    // Memory request mux and tag generation for the winner.
    always_comb begin
        w_mem_we         = 1'b0;
        w_mem_addr       = {ADDR_W{1'b0}};
        w_mem_wdata      = {DATA_W{1'b0}};
        w_push_tag.owner = OWN_FETCH;
        w_push_tag.addr  = bus.if_addr_i;
        if (w_d_gnt) begin
            w_mem_we         = bus.d_we_i;
            w_mem_addr       = bus.d_addr_i;
            w_mem_wdata      = bus.d_wdata_i;
            w_push_tag.owner = OWN_DATA;
            w_push_tag.addr  = bus.d_addr_i;
        end else if (w_if_gnt) begin
            w_mem_addr = bus.if_addr_i;
        end else begin
            w_mem_we = 1'b0;
        end
    end

    assign w_push = w_if_gnt || (w_d_gnt && !bus.d_we_i);
    assign w_pop  = bus.mem_rvalid_i && !w_empty;

    // Starvation counter: counts consecutive fetch cycles lost, saturating.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve_cnt <= {SC_W{1'b0}};
        end else if (!bus.if_req_i || w_if_gnt) begin
            r_starve_cnt <= {SC_W{1'b0}};
        end else if (r_starve_cnt != SC_W'(STARVE_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + SC_W'(1);
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Response routing; data outputs hold their last value between pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_if_rvalid <= 1'b0;
            r_if_raddr  <= {ADDR_W{1'b0}};
            r_if_rdata  <= {DATA_W{1'b0}};
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= {DATA_W{1'b0}};
            r_err       <= 1'b0;
        end else begin
            r_if_rvalid <= w_pop && (w_pop_tag.owner == OWN_FETCH);
            r_d_rvalid  <= w_pop && (w_pop_tag.owner == OWN_DATA);
            if (w_pop && (w_pop_tag.owner == OWN_FETCH)) begin
                r_if_raddr <= w_pop_tag.addr;
                r_if_rdata <= bus.mem_rdata_i;
            end
            if (w_pop && (w_pop_tag.owner == OWN_DATA)) begin
                r_d_rdata <= bus.mem_rdata_i;
            end
            if (bus.mem_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.if_gnt_o    = w_if_gnt;
    assign bus.d_gnt_o     = w_d_gnt;
    assign bus.mem_req_o   = w_if_gnt || w_d_gnt;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_wdata_o = w_mem_wdata;
    assign bus.if_rvalid_o = r_if_rvalid;
    assign bus.if_raddr_o  = r_if_raddr;
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.d_rvalid_o  = r_d_rvalid;
    assign bus.d_rdata_o   = r_d_rdata;
    assign bus.err_o       = r_err;

endmodule
